// File: rtl/t07_cpu_mem_bus_bridge.sv
// t07_cpu_mem_bus_bridge
// Sequential bridge between the CPU memory handler and the external memory bus.
// Takes one read/write request at a time, runs a req/ack handshake on the bus,
// returns read data and holds busy high so the handler can freeze its pipeline.
//
// Optional feature: define T07_BUS_TIMEOUT_EN to enable an ack watchdog that
// aborts a stuck transaction after TIMEOUT_CYCLES bus cycles (err pulse,
// read data replaced by 32'hDEAD_BEEF). Without it the bus waits forever.

module t07_cpu_mem_bus_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        rwi,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              busy,
    output logic              data_valid,
    output logic              err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Low two address bits are cleared so the bus always sees a word address.
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    // bus_sel is a fixed 4-bit byte enable, so only 32-bit data makes sense.
    if (DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("t07_cpu_mem_bus_bridge: DATA_W must be 32 and TIMEOUT_CYCLES >= 1");
    end

`ifdef T07_BUS_TIMEOUT_EN
    // Counter only needs to reach TIMEOUT_CYCLES-1; the abort fires on that value.
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF);

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Single-process FSM: every output is registered and updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cpu_rdata  <= '0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_sel    <= 4'h0;
`ifdef T07_BUS_TIMEOUT_EN
            wd_cnt     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
`ifdef T07_BUS_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rwi == 2'b01 || rwi == 2'b10) begin
                        bus_addr  <= cpu_addr & WORD_MASK;
                        bus_wdata <= cpu_wdata;
                        bus_we    <= (rwi == 2'b10);
                        bus_req   <= 1'b1;
                        bus_sel   <= 4'hF;
                        busy      <= 1'b1;
                        state     <= BUS;
`ifdef T07_BUS_TIMEOUT_EN
                        wd_cnt    <= '0;
`endif
                    end
                end

                BUS: begin
                    if (bus_ack) begin
                        bus_req    <= 1'b0;
                        bus_sel    <= 4'h0;
                        busy       <= 1'b0;
                        data_valid <= 1'b1;
                        if (!bus_we) begin
                            cpu_rdata <= bus_rdata;
                        end
                        state      <= DONE;
                    end
`ifdef T07_BUS_TIMEOUT_EN
                    else if (wd_cnt == CNT_LAST) begin
                        bus_req    <= 1'b0;
                        bus_sel    <= 4'h0;
                        busy       <= 1'b0;
                        data_valid <= 1'b1;
                        err_q      <= 1'b1;
                        if (!bus_we) begin
                            cpu_rdata <= TIMEOUT_DATA;
                        end
                        state      <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
